des_8b10b_lane: RTL

Parametrised successor to the single-byte deserializer in the SerDes receive path. It accepts a serial bitstream one bit per qualified clock and hunts for K28.5 comma alignment. It decodes 8b/10b symbols (IEEE 802.3 Clause 36 tables) into `NUM_SYMBOLS`-byte words, flags control symbols and errors, and presents each word on a valid/ready interface. It sits downstream of the receive async FIFO read port, in the FIFO's read clock domain.

---
 rtl/des_8b10b_lane.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/des_8b10b_lane.sv
// 8b/10b serial lane deserializer: K28.5 comma hunt, Clause 36 decode, valid/ready word output.
// Optional running-disparity checking is enabled by defining DES_DISPARITY_CHECK_EN.
module des_8b10b_lane #(
    parameter int NUM_SYMBOLS = 1,
    parameter int LOSS_THRESH = 4,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst,
    input  logic                     i_Bit_Valid,
    input  logic                     i_Data_In,
    output logic [8*NUM_SYMBOLS-1:0] o_Data,
    output logic [NUM_SYMBOLS-1:0]   o_K,
    output logic                     o_Valid,
    input  logic                     i_Ready,
    output logic                     o_Locked,
    output logic                     o_Code_Err,
    output logic                     o_Disp_Err,
    output logic [ERR_CNT_W-1:0]     o_Err_Count,
    output logic                     o_Overflow
);
    localparam int LANE_W = (NUM_SYMBOLS > 1) ? $clog2(NUM_SYMBOLS) : 1;
    localparam int RUN_W  = $clog2(LOSS_THRESH + 1);

    localparam logic [9:0] COMMA_NEG = 10'b0011111010;
    localparam logic [9:0] COMMA_POS = 10'b1100000101;

    typedef enum logic {HUNT, LOCKED} state_t;

    typedef struct packed {
        logic       ok;
        logic [4:0] val;
    } dec6_t;

    typedef struct packed {
        logic       ok;
        logic [2:0] val;
    } dec4_t;

    function automatic dec6_t decode6(input logic [5:0] c);
        dec6_t r;
        r = '{ok: 1'b1, val: 5'd0};
        case (c)
            6'b100111, 6'b011000: r.val = 5'd0;
            6'b011101, 6'b100010: r.val = 5'd1;
            6'b101101, 6'b010010: r.val = 5'd2;
            6'b110001:            r.val = 5'd3;
            6'b110101, 6'b001010: r.val = 5'd4;
            6'b101001:            r.val = 5'd5;
            6'b011001:            r.val = 5'd6;
            6'b111000, 6'b000111: r.val = 5'd7;
            6'b111001, 6'b000110: r.val = 5'd8;
            6'b100101:            r.val = 5'd9;
            6'b010101:            r.val = 5'd10;
            6'b110100:            r.val = 5'd11;
            6'b001101:            r.val = 5'd12;
            6'b101100:            r.val = 5'd13;
            6'b011100:            r.val = 5'd14;
            6'b010111, 6'b101000: r.val = 5'd15;
            6'b011011, 6'b100100: r.val = 5'd16;
            6'b100011:            r.val = 5'd17;
            6'b010011:            r.val = 5'd18;
            6'b110010:            r.val = 5'd19;
            6'b001011:            r.val = 5'd20;
            6'b101010:            r.val = 5'd21;
            6'b011010:            r.val = 5'd22;
            6'b111010, 6'b000101: r.val = 5'd23;
            6'b110011, 6'b001100: r.val = 5'd24;
            6'b100110:            r.val = 5'd25;
            6'b010110:            r.val = 5'd26;
            6'b110110, 6'b001001: r.val = 5'd27;
            6'b001110:            r.val = 5'd28;
            6'b101110, 6'b010001: r.val = 5'd29;
            6'b011110, 6'b100001: r.val = 5'd30;
            6'b101011, 6'b010100: r.val = 5'd31;
            6'b001111, 6'b110000: r.val = 5'd28;
            default:              r.ok  = 1'b0;
        endcase
        return r;
    endfunction

    function automatic dec4_t decode4(input logic [3:0] c);
        dec4_t r;
        r = '{ok: 1'b1, val: 3'd0};
        case (c)
            4'b1011, 4'b0100:                   r.val = 3'd0;
            4'b1001:                            r.val = 3'd1;
            4'b0101:                            r.val = 3'd2;
            4'b1100, 4'b0011:                   r.val = 3'd3;
            4'b1101, 4'b0010:                   r.val = 3'd4;
            4'b1010:                            r.val = 3'd5;
            4'b0110:                            r.val = 3'd6;
            4'b1110, 4'b0001, 4'b0111, 4'b1000: r.val = 3'd7;
            default:                            r.ok  = 1'b0;
        endcase
        return r;
    endfunction

    state_t                   state_q, state_d;
    logic [9:0]               win_q, win_d;
    logic [3:0]               bit_cnt_q;
    logic [LANE_W-1:0]        lane_q;
    logic [RUN_W-1:0]         err_run_q;
    logic [8*NUM_SYMBOLS-1:0] word_data_q, asm_data;
    logic [NUM_SYMBOLS-1:0]   word_k_q, asm_k;

    logic       is_comma, sym_end, sym_load, word_done, loss;
    logic       is_k28, k28_pos, is_a7, code_err, disp_err, sym_k;
    logic [3:0] four_eff;
    logic [7:0] sym_byte;
    dec6_t      d6;
    dec4_t      d4;

    assign win_d    = {win_q[8:0], i_Data_In};
    assign is_comma = (win_d == COMMA_NEG) || (win_d == COMMA_POS);
    assign sym_end  = i_Bit_Valid && (state_q == LOCKED) && (bit_cnt_q == 4'd9);
    assign sym_load = sym_end || (i_Bit_Valid && (state_q == HUNT) && is_comma);

    // K28.y RD+ is the bitwise complement of RD-, so its 4b part is un-complemented before lookup.
    assign is_k28   = (win_d[9:4] == 6'b001111) || (win_d[9:4] == 6'b110000);
    assign k28_pos  = (win_d[9:4] == 6'b110000);
    assign four_eff = k28_pos ? ~win_d[3:0] : win_d[3:0];
    assign d6       = decode6(win_d[9:4]);
    assign d4       = decode4(four_eff);
    assign is_a7    = (win_d[3:0] == 4'b0111) || (win_d[3:0] == 4'b1000);
    assign code_err = !d6.ok || !d4.ok;
    assign sym_byte = code_err ? 8'h00 : {d4.val, d6.val};
    assign sym_k    = !code_err && (is_k28 || (is_a7 && (d6.val == 5'd23 || d6.val == 5'd27 ||
                                                         d6.val == 5'd29 || d6.val == 5'd30)));

    assign loss      = sym_end && code_err && (err_run_q == RUN_W'(LOSS_THRESH - 1));
    assign word_done = sym_load && !loss && (lane_q == LANE_W'(NUM_SYMBOLS - 1));
    assign o_Locked  = (state_q == LOCKED);

`ifdef DES_DISPARITY_CHECK_EN
    logic rd_q, rd_mid, rd_end, err6, err4;

    function automatic logic [1:0] rd_step6(input logic rd, input logic [5:0] c);
        int   ones;
        logic err, nxt;
        ones = $countones(c);
        err  = (rd && (ones > 3 || c == 6'b111000)) || (!rd && (ones < 3 || c == 6'b000111));
        if (ones > 3 || c == 6'b000111)      nxt = 1'b1;
        else if (ones < 3 || c == 6'b111000) nxt = 1'b0;
        else                                 nxt = rd;
        return {err, nxt};
    endfunction

    function automatic logic [1:0] rd_step4(input logic rd, input logic [3:0] c);
        int   ones;
        logic err, nxt;
        ones = $countones(c);
        err  = (rd && (ones > 2 || c == 4'b1100)) || (!rd && (ones < 2 || c == 4'b0011));
        if (ones > 2 || c == 4'b0011)      nxt = 1'b1;
        else if (ones < 2 || c == 4'b1100) nxt = 1'b0;
        else                               nxt = rd;
        return {err, nxt};
    endfunction

    assign {err6, rd_mid} = rd_step6(rd_q, win_d[9:4]);
    assign {err4, rd_end} = rd_step4(rd_mid, win_d[3:0]);
    assign disp_err       = err6 || err4;

    // rd_q is 1 for RD+; a comma found while hunting fixes the polarity directly.
    always_ff @(posedge i_Clk) begin
        if (i_Rst)
            rd_q <= 1'b0;
        else if (i_Bit_Valid && state_q == HUNT && is_comma)
            rd_q <= (win_d == COMMA_NEG);
        else if (sym_end)
            rd_q <= rd_end;
    end
`else
    assign disp_err = 1'b0;
`endif

    // NOTE: every variable an always_comb writes gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HUNT:    if (i_Bit_Valid && is_comma) state_d = LOCKED;
            LOCKED:  if (loss) state_d = HUNT;
            default: state_d = HUNT;
        endcase
    end

    always_comb begin
        asm_data = word_data_q;
        asm_k    = word_k_q;
        for (int i = 0; i < NUM_SYMBOLS; i++) begin
            if (lane_q == LANE_W'(i)) begin
                asm_data[8*i +: 8] = sym_byte;
                asm_k[i]           = sym_k;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) state_q <= HUNT;
        else       state_q <= state_d;
    end

    always_ff @(posedge i_Clk) begin
        // NOTE: the partial-word buffer is a handful of flops, so it is reset along with the outputs.
        if (i_Rst) begin
            win_q       <= '0;
            bit_cnt_q   <= '0;
            lane_q      <= '0;
            err_run_q   <= '0;
            word_data_q <= '0;
            word_k_q    <= '0;
            o_Data      <= '0;
            o_K         <= '0;
            o_Valid     <= 1'b0;
            o_Code_Err  <= 1'b0;
            o_Disp_Err  <= 1'b0;
            o_Err_Count <= '0;
            o_Overflow  <= 1'b0;
        end else begin
            o_Code_Err <= sym_end && code_err;
            o_Disp_Err <= sym_end && disp_err;

            if (i_Bit_Valid) begin
                win_q <= win_d;
                if (state_q == HUNT)
                    bit_cnt_q <= '0;
                else
                    bit_cnt_q <= (bit_cnt_q == 4'd9) ? 4'd0 : bit_cnt_q + 4'd1;
            end

            if (sym_end) begin
                if (!code_err || loss) err_run_q <= '0;
                else                   err_run_q <= err_run_q + RUN_W'(1);
                if ((code_err || disp_err) && (o_Err_Count != '1))
                    o_Err_Count <= o_Err_Count + ERR_CNT_W'(1);
            end

            if (sym_load) begin
                if (loss) begin
                    lane_q      <= '0;
                    word_data_q <= '0;
                    word_k_q    <= '0;
                end else begin
                    word_data_q <= asm_data;
                    word_k_q    <= asm_k;
                    lane_q      <= word_done ? '0 : lane_q + LANE_W'(1);
                end
            end

            // A completed word loads only if the output slot is empty or being emptied this cycle.
            if (word_done && (!o_Valid || i_Ready)) begin
                o_Data  <= asm_data;
                o_K     <= asm_k;
                o_Valid <= 1'b1;
            end else begin
                if (word_done)          o_Overflow <= 1'b1;
                if (o_Valid && i_Ready) o_Valid    <= 1'b0;
            end
        end
    end

endmodule
